// File: rtl/nibble_add_sched.sv
// nibble_add_sched: round-robin scheduler sharing one 4-bit add slice.
// Optional subtract mode under `NIBBLE_ADD_SCHED_SUB_EN (adds req0_sub/req1_sub).
module nibble_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
`ifdef NIBBLE_ADD_SCHED_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  localparam logic [WIDTH-1:0] NMASK = WIDTH'(4'hF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic             sub_q, sub_d;
  logic             ptr_q, ptr_d;

  logic             s0, s1;
  logic             gnt0, gnt1;
  logic [CW+1:0]    sh;
  logic [3:0]       na, nb, ns;
  logic [4:0]       c;

`ifdef NIBBLE_ADD_SCHED_SUB_EN
  assign s0 = req0_sub;
  assign s1 = req1_sub;
`else
  assign s0 = 1'b0;
  assign s1 = 1'b0;
`endif

  // ptr_q names the requester that wins a tie
  assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1 = req1_valid & (~req0_valid | ptr_q);

  assign req0_ready = (state_q == S_IDLE) & gnt0;
  assign req1_ready = (state_q == S_IDLE) & gnt1;

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

  assign sh = {cnt_q, 2'b00};

  always_comb begin
    na   = 4'(a_q >> sh);
    nb   = 4'(b_q >> sh) ^ {4{sub_q}};
    ns   = '0;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      ns[i]  = na[i] ^ nb[i] ^ c[i];
      c[i+1] = (na[i] & nb[i]) | (na[i] & c[i]) | (nb[i] & c[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    id_d    = id_q;
    sub_d   = sub_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          sub_d   = gnt1 ? s1 : s0;
          carry_d = sub_d | (gnt1 ? req1_cin : req0_cin);
          id_d    = gnt1;
          ptr_d   = ~gnt1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(NMASK << sh))
                | (WIDTH'(ns) << sh);
        carry_d = c[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      sub_q   <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: random + directed checks against an
// arithmetic reference of the shared nibble adder scheduler.
module tb_nibble_add_sched;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
  } op_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_id, busy;

  int checks = 0;
  int errors = 0;

  op_t          pend [2];
  bit           v    [2];
  int           last = 1;
  logic [W-1:0] res_sum;
  logic         res_cout;

  always #5 clk = ~clk;

  nibble_add_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a   = W'($urandom);
    o.b   = W'($urandom);
    o.cin = 1'($urandom);
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    o.sub = 1'($urandom);
`else
    o.sub = 1'b0;
`endif
    return o;
  endfunction

  function automatic logic [W:0] model(input op_t o);
    if (o.sub)
      return {1'b0, o.a} + {1'b0, ~o.b} + (W+1)'(1);
    return {1'b0, o.a} + {1'b0, o.b} + (W+1)'(o.cin);
  endfunction

  task automatic apply();
    req0_valid = v[0];
    req1_valid = v[1];
    req0_a = pend[0].a; req0_b = pend[0].b;
    req0_cin = pend[0].cin; req0_sub = pend[0].sub;
    req1_a = pend[1].a; req1_b = pend[1].b;
    req1_cin = pend[1].cin; req1_sub = pend[1].sub;
  endtask

  task automatic serve(input int stall, input bit jit,
                       input int want);
    int n, gid, expg;
    op_t op;
    logic [W:0] exp;
    apply();
    #1;
    n = 0;
    while (!(req0_ready | req1_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("grant_seen", 64'(req0_ready | req1_ready), 1);
    if (!(req0_ready | req1_ready)) return;
    chk("one_ready", 64'(req0_ready & req1_ready), 0);
    gid  = req1_ready ? 1 : 0;
    expg = (v[0] && v[1]) ? ((last == 0) ? 1 : 0)
                          : (v[0] ? 0 : 1);
    chk("grant", 64'(gid), 64'(expg));
    if (want >= 0) chk("grant_want", 64'(gid), 64'(want));
    op   = pend[gid];
    last = gid;
    exp  = model(op);
    @(posedge clk); #1;
    pend[gid] = rand_op();
    apply();
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (jit) begin
        req0_valid = 1'($urandom);
        req1_valid = 1'($urandom);
      end
      #1;
      chk("busy_hold", 64'({busy, req0_ready, req1_ready}),
          64'(3'b100));
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(NIB));
    chk("sum", 64'(rsp_sum), 64'(exp[W-1:0]));
    chk("cout", 64'(rsp_cout), 64'(exp[W]));
    chk("id", 64'(rsp_id), 64'(gid));
    res_sum  = rsp_sum;
    res_cout = rsp_cout;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_hold",
          64'({rsp_valid, rsp_sum, rsp_cout, rsp_id,
               req0_ready, req1_ready}),
          64'({1'b1, exp[W-1:0], exp[W], 1'(gid), 2'b00}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("back_idle", 64'({busy, rsp_valid}), 0);
  endtask

  initial begin
    pend[0] = rand_op();
    pend[1] = rand_op();
    v[0] = 0; v[1] = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",
        64'({rsp_valid, rsp_sum, rsp_cout, rsp_id, busy,
             req0_ready, req1_ready}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_quiet", 64'({busy, rsp_valid}), 0);

    // directed: wrap-around carry
    v[0] = 1; v[1] = 0;
    pend[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0};
    serve(0, 0, 0);
    chk("d1_sum", 64'(res_sum), 64'h0000);
    chk("d1_cout", 64'(res_cout), 1);

    // directed: requester 1 alone
    v[0] = 0; v[1] = 1;
    pend[1] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sub: 1'b0};
    serve(0, 0, 1);
    chk("d2_sum", 64'(res_sum), 64'h5556);
    chk("d2_cout", 64'(res_cout), 0);

    // both valid throughout: strict alternation
    v[0] = 1; v[1] = 1;
    for (int i = 0; i < 6; i++)
      serve(int'($urandom_range(0, 2)), 0, i % 2);

    // long response backpressure
    serve(10, 0, -1);

    // no valid: nothing latched, nothing produced
    v[0] = 0; v[1] = 0;
    apply();
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_req", 64'({busy, rsp_valid}), 0);
    end

    // reset in 2nd RUN cycle aborts the op
    v[0] = 1; v[1] = 0;
    pend[0] = rand_op();
    apply();
    #1;
    chk("rst_gnt", 64'(req0_ready), 1);
    last = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_pre", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_abort",
        64'({busy, rsp_valid, rsp_sum, rsp_cout, rsp_id}), 0);
    v[0] = 0;
    apply();
    #1;
    rst_n = 1'b1;
    last = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", 64'({busy, rsp_valid}), 0);
    end
    v[0] = 1; v[1] = 1;
    serve(0, 0, 0);

    // random traffic with valid jitter while busy
    for (int i = 0; i < 24; i++) begin
      int p;
      p = int'($urandom_range(1, 3));
      v[0] = p[0]; v[1] = p[1];
      serve(int'($urandom_range(0, 3)), 1, -1);
    end

`ifdef NIBBLE_ADD_SCHED_SUB_EN
    v[0] = 1; v[1] = 0;
    pend[0] = '{a: 16'h0005, b: 16'h0007, cin: 1'b1, sub: 1'b1};
    serve(0, 0, 0);
    chk("sub_neg_sum", 64'(res_sum), 64'hFFFE);
    chk("sub_neg_cout", 64'(res_cout), 0);
    pend[0] = '{a: 16'h0007, b: 16'h0005, cin: 1'b0, sub: 1'b1};
    serve(0, 0, 0);
    chk("sub_pos_sum", 64'(res_sum), 64'h0002);
    chk("sub_pos_cout", 64'(res_cout), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
- Shares one 4-bit ripple-carry add slice between two requesters.
- Each request carries WIDTH-bit operands. The block runs the slice serially, one nibble per cycle, LSB nibble first, with the carry held in a register between nibbles.
- Requesters are arbitrated round-robin. The block returns sum and carry-out on a valid/ready response channel tagged with the requester id.
- Sits between two operand producers and the shared add datapath in the partitioned adder subsystem.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibble passes per request.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_cin  in  1  carry-in.
- req1_valid / req1_ready / req1_a / req1_b / req1_cin  same widths and meanings, requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry-out of the MSB nibble.
- rsp_id  out  1  requester that issued the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
  - Nibble counter=0, carry register=0.
  - Round-robin pointer favours requester 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant = round-robin between valid requesters. If both are valid, the requester not granted last time wins. If only one is valid, it wins.
  - reqN_ready = (state==IDLE) & grantN. This is combinational and depends on valid; at most one ready is high per cycle.
  - On handshake: latch A, B, cin and id; pointer updates to the other requester; counter=0; go to RUN.
- RUN:
  - Each cycle, the slice adds A[4k+3:4k] + B[4k+3:4k] + carry reg, with k = counter.
  - Sum nibble is written to result[4k+3:4k]; carry reg gets the slice carry-out; counter increments.
  - After the pass with k=NIB-1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id are stable and held until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge, go to IDLE.
- Latency: rsp_valid rises exactly NIB cycles after the acceptance edge (4 cycles at WIDTH=16).
- Throughput: minimum NIB+2 cycles per request. Requests are never accepted while state != IDLE.
- Slice arithmetic is the same as the 4-bit adder partition: sum = a^b^c, carry = majority(a,b,c) per bit.
  - Full result = A + B + cin, modulo 2^WIDTH, carry-out = bit WIDTH.
- Boundary conditions:
  - Operands change after acceptance: no effect (latched copies are used).
  - req valid drops without a handshake: nothing is latched.
  - Simultaneous valid from both requesters over consecutive operations: grants strictly alternate.
  - rst_n asserted mid-RUN or in DONE: operation aborted, no response, all state returns to reset values immediately.
  - WIDTH=4: a single RUN cycle.

Optional Feature:
- Macro: NIBBLE_ADD_SCHED_SUB_EN.
- Defined:
  - Adds inputs req0_sub and req1_sub (1 bit each), latched with the operands.
  - When sub=1: the slice uses ~B nibbles, the initial carry is forced to 1 and reqN_cin is ignored, giving result = A - B.
  - rsp_cout=1 means no borrow.
- Undefined: no sub ports; addition only.

Test Plan:
- WIDTH=16, req0: A=0xFFFF, B=0x0001, cin=0 -> rsp_valid 4 cycles after acceptance, rsp_sum=0x0000, rsp_cout=1, rsp_id=0.
- req1 only: A=0x1234, B=0x4321, cin=1 -> rsp_sum=0x5556, rsp_cout=0, rsp_id=1; req0_ready stays 0 throughout.
- Both valid continuously, three operations each -> rsp_id sequence 0,1,0,1,0,1; no ready is asserted while busy=1.
- rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_sum, rsp_cout and rsp_id remain stable; both ready outputs stay 0; IDLE is entered the cycle after the rsp_ready pulse.
- rst_n pulsed low during the 2nd RUN cycle -> busy=0 and rsp_valid=0 immediately; no response is produced; the next request is granted to requester 0.
- NIBBLE_ADD_SCHED_SUB_EN defined, sub=1: A=0x0005, B=0x0007 -> rsp_sum=0xFFFE, rsp_cout=0. With A=0x0007, B=0x0005 -> rsp_sum=0x0002, rsp_cout=1.
